// File: rtl/verificador_senha_pkg.sv
// Shared FSM state type and default parameter values for the sequential code checker.
package verificador_senha_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    VERDICT = 2'd2,
    LOCK    = 2'd3
  } state_e;

  localparam int DEF_DIGIT_W     = 4;
  localparam int DEF_CODE_LEN    = 4;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 1000;

endpackage

// File: rtl/verificador_senha_comparador_digito.sv
// Single-digit equality: per-bit XNOR followed by an AND reduction.
module comparador_digito #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               equal
);

  logic [DIGIT_W-1:0] bit_eq;

  assign bit_eq = a ~^ b;
  assign equal  = &bit_eq;

endmodule

// File: rtl/verificador_senha.sv
// Sequential code checker: digit-by-digit compare, one-cycle grant/deny verdict, failure count.
// Define VERIFICADOR_LOCKOUT_EN to build the LOCK state, lockout counter and locked output.
module verificador_senha
  import verificador_senha_pkg::*;
#(
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int CODE_LEN    = DEF_CODE_LEN,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 code_load,
  input  logic [CODE_LEN*DIGIT_W-1:0]          code_in,
  input  logic                                 digit_valid,
  output logic                                 digit_ready,
  input  logic [DIGIT_W-1:0]                   digit,
  input  logic                                 clear,
  output logic                                 granted,
  output logic                                 denied,
  output logic                                 locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]       fail_count
);

  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FC_W  = $clog2(MAX_TRIES + 1);
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  if (CODE_LEN < 1 || MAX_TRIES < 1 || LOCK_CYCLES < 1) begin : g_bad_params
    $error("verificador_senha: CODE_LEN, MAX_TRIES and LOCK_CYCLES must all be >= 1");
  end

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         mismatch_q, mismatch_d;
  logic [FC_W-1:0]              fail_q, fail_d;
  logic [CODE_LEN*DIGIT_W-1:0]  ref_q, ref_d;

  logic [DIGIT_W-1:0]           ref_digit;
  logic                         digit_eq;
  logic                         accept;
  logic [FC_W-1:0]              fail_inc;

  always_comb begin
    ref_digit = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) ref_digit = ref_q[i*DIGIT_W +: DIGIT_W];
    end
  end

  comparador_digito #(.DIGIT_W(DIGIT_W)) u_cmp (
    .a     (digit),
    .b     (ref_digit),
    .equal (digit_eq)
  );

  assign digit_ready = (state_q == IDLE) || (state_q == ENTRY);
  assign accept      = digit_valid && digit_ready;
  assign granted     = (state_q == VERDICT) && !mismatch_q;
  assign denied      = (state_q == VERDICT) && mismatch_q;
  assign fail_count  = fail_q;
  assign fail_inc    = (fail_q == FC_W'(MAX_TRIES)) ? fail_q : fail_q + FC_W'(1);

`ifdef VERIFICADOR_LOCKOUT_EN
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  assign locked = (state_q == LOCK);
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    ref_d      = code_load ? code_in : ref_q;
`ifdef VERIFICADOR_LOCKOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mismatch_d = !digit_eq;
          if (CODE_LEN == 1) begin
            state_d = VERDICT;
            idx_d   = '0;
          end else begin
            state_d = ENTRY;
            idx_d   = IDX_W'(1);
          end
        end
      end
      ENTRY: begin
        // clear takes priority over a digit offered in the same cycle
        if (clear) begin
          state_d    = IDLE;
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else if (accept) begin
          mismatch_d = mismatch_q | !digit_eq;
          if (idx_q == IDX_W'(CODE_LEN - 1)) begin
            state_d = VERDICT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      VERDICT: begin
        state_d    = IDLE;
        mismatch_d = 1'b0;
        if (mismatch_q) begin
          fail_d = fail_inc;
`ifdef VERIFICADOR_LOCKOUT_EN
          if (fail_inc == FC_W'(MAX_TRIES)) begin
            state_d    = LOCK;
            lock_cnt_d = CNT_W'(LOCK_CYCLES - 1);
          end
`endif
        end else begin
          fail_d = '0;
        end
      end
`ifdef VERIFICADOR_LOCKOUT_EN
      LOCK: begin
        if (lock_cnt_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
      ref_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      ref_q      <= ref_d;
    end
  end

`ifdef VERIFICADOR_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_cnt_q <= '0;
    else     lock_cnt_q <= lock_cnt_d;
  end
`endif

endmodule

// File: tb/tb_verificador_senha.sv
// Directed bench for verificador_senha with a per-cycle behavioural model and literal spot checks.
module tb_verificador_senha;

  localparam int DW = 4;
  localparam int CL = 4;
  localparam int MT = 3;
  localparam int LC = 8;
  localparam int FW = $clog2(MT + 1);
`ifdef VERIFICADOR_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           code_load = 1'b0;
  logic [15:0]    code_in = '0;
  logic           digit_valid = 1'b0;
  logic           digit_ready;
  logic [DW-1:0]  digit = '0;
  logic           clear = 1'b0;
  logic           granted, denied, locked;
  logic [FW-1:0]  fail_count;

  int checks = 0;
  int errors = 0;
  int gcount = 0;
  int dcount = 0;

  always #5 clk = ~clk;

  verificador_senha #(
    .DIGIT_W    (DW),
    .CODE_LEN   (CL),
    .MAX_TRIES  (MT),
    .LOCK_CYCLES(LC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code_load  (code_load),
    .code_in    (code_in),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .digit      (digit),
    .clear      (clear),
    .granted    (granted),
    .denied     (denied),
    .locked     (locked),
    .fail_count (fail_count)
  );

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Behavioural model: counts digits entered, remembers pending verdict and lockout time left.
  int          m_entered = 0;
  int          m_verdict = 0;   // 0 none, 1 grant, 2 deny
  int          m_fails   = 0;
  int          m_lock    = 0;   // lockout cycles still to show
  bit          m_mism    = 1'b0;
  logic [15:0] m_ref     = '0;
  logic [15:0] m_shift;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_entered = 0; m_verdict = 0; m_fails = 0; m_lock = 0; m_mism = 1'b0; m_ref = '0;
    end else begin
      if (m_verdict != 0) begin
        if (m_verdict == 2) begin
          if (m_fails < MT) m_fails = m_fails + 1;
          if (LOCK_EN && m_fails == MT) m_lock = LC;
        end else begin
          m_fails = 0;
        end
        m_verdict = 0; m_entered = 0; m_mism = 1'b0;
      end else if (m_lock > 0) begin
        m_lock = m_lock - 1;
        if (m_lock == 0) m_fails = 0;
      end else if (m_entered > 0 && clear) begin
        m_entered = 0; m_mism = 1'b0;
      end else if (digit_valid) begin
        m_shift = m_ref >> (DW * m_entered);
        if (digit != m_shift[3:0]) m_mism = 1'b1;
        m_entered = m_entered + 1;
        if (m_entered == CL) begin
          m_verdict = m_mism ? 2 : 1;
          m_entered = 0;
        end
      end
      if (code_load) m_ref = code_in;
    end
  end

  always @(negedge clk) begin
    check("granted",     int'(granted),     int'(m_verdict == 1));
    check("denied",      int'(denied),      int'(m_verdict == 2));
    check("locked",      int'(locked),      int'(m_lock > 0));
    check("digit_ready", int'(digit_ready), int'(m_verdict == 0 && m_lock == 0));
    check("fail_count",  int'(fail_count),  m_fails);
    if (granted) gcount++;
    if (denied)  dcount++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    @(posedge clk); #1;
    digit_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < CL; i++) send(c[4*i +: 4]);
  endtask

  task automatic load(input logic [15:0] c);
    code_in = c;
    code_load = 1'b1;
    @(posedge clk); #1;
    code_load = 1'b0;
  endtask

  initial begin
    int g0, d0, n;

    tick(2);
    check("rst_ready",   int'(digit_ready), 1);
    check("rst_granted", int'(granted), 0);
    check("rst_denied",  int'(denied), 0);
    check("rst_locked",  int'(locked), 0);
    check("rst_fail",    int'(fail_count), 0);
    rst = 1'b0;
    tick(1);

    // correct code: digits 4,3,2,1
    load(16'h1234);
    enter_code(16'h1234);
    check("grant_pulse", int'(granted), 1);
    tick(1);
    check("grant_gone", int'(granted), 0);
    check("grant_fail0", int'(fail_count), 0);

    // wrong last digit: 4,3,2,0
    enter_code(16'h0234);
    check("deny_pulse", int'(denied), 1);
    tick(1);
    check("deny_fail1", int'(fail_count), 1);
    check("deny_idle", int'(digit_ready), 1);

    // second failure, then a correct code clears the count
    enter_code(16'h1239); tick(1);
    check("fail2", int'(fail_count), 2);
    enter_code(16'h1234);
    check("grant_after2", int'(granted), 1);
    tick(1);
    check("fail_cleared", int'(fail_count), 0);
    enter_code(16'h1244); tick(1);
    check("fail_again1", int'(fail_count), 1);
    check("no_lock", int'(locked), 0);
    enter_code(16'h1234); tick(1);

    // partial entry aborted by clear (with a digit offered alongside)
    send(4'h4); send(4'h3);
    clear = 1'b1; digit_valid = 1'b1; digit = 4'h2;
    @(posedge clk); #1;
    clear = 1'b0; digit_valid = 1'b0;
    g0 = gcount; d0 = dcount;
    enter_code(16'h1234);
    tick(1);
    check("clear_grants", gcount - g0, 1);
    check("clear_denies", dcount - d0, 0);

    // reference reloaded mid-entry: digit accepted alongside the load uses the old reference
    send(4'h4);
    code_in = 16'h5634; code_load = 1'b1;
    send(4'h3);
    code_load = 1'b0;
    send(4'h6); send(4'h5);
    check("midload_grant", int'(granted), 1);
    tick(1);
    load(16'h1234);

    // three consecutive failures
    enter_code(16'h0000); tick(1);
    enter_code(16'h1111); tick(1);
    enter_code(16'h2222);
    check("third_deny", int'(denied), 1);
    if (LOCK_EN) begin
      n = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (locked) begin
          n++;
          check("lock_ready0", int'(digit_ready), 0);
        end else if (n > 0) begin
          break;
        end
      end
      check("lock_len", n, LC);
      check("lock_fail0", int'(fail_count), 0);
    end else begin
      tick(1);
      check("sat_fail3", int'(fail_count), MT);
      enter_code(16'h3333); tick(1);
      check("sat_hold3", int'(fail_count), MT);
      check("nolock_locked", int'(locked), 0);
    end
    enter_code(16'h1234);
    check("post_grant", int'(granted), 1);
    tick(1);
    check("post_fail0", int'(fail_count), 0);

    // asynchronous reset in the middle of an entry
    enter_code(16'h9999); tick(1);
    send(4'h4); send(4'h3);
    rst = 1'b1; #1;
    check("arst_entry_fail", int'(fail_count), 0);
    check("arst_entry_ready", int'(digit_ready), 1);
    tick(1);
    rst = 1'b0;
    load(16'h1234);
    enter_code(16'h1234);
    check("arst_entry_grant", int'(granted), 1);
    tick(1);

    // asynchronous reset in the middle of a lockout
    if (LOCK_EN) begin
      enter_code(16'h0000); tick(1);
      enter_code(16'h0000); tick(1);
      enter_code(16'h0000); tick(3);
      check("lock_active", int'(locked), 1);
      rst = 1'b1; #1;
      check("arst_lock_locked", int'(locked), 0);
      check("arst_lock_ready", int'(digit_ready), 1);
      check("arst_lock_fail", int'(fail_count), 0);
      tick(1);
      rst = 1'b0;
      load(16'h1234);
      enter_code(16'h1234);
      check("arst_lock_grant", int'(granted), 1);
      tick(1);
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
